// File: rtl/line_feed_scheduler.sv
// Credit-metered pixel sequencer feeding the 4-line-buffer 3x3 window unit.
// Adds optional zero pad lines and tracks line-done interrupts per frame.
module line_feed_scheduler #(
    parameter int DATA_W     = 8,
    parameter int LINE_WIDTH = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int NUM_LB     = 4,
    parameter int PAD_EN     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              lb_clear,
    input  logic              line_irq,
    output logic [11:0]       rows_done,
    output logic              irq_err
);

    localparam int PW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int CW = $clog2(NUM_LB + 1);
    localparam int L  = IMG_HEIGHT + 2 * PAD_EN;
    localparam int R  = L - 2;

    localparam logic [11:0]   LAST_LINE = 12'(L - 1);
    localparam logic [11:0]   ROWS      = 12'(R);
    localparam logic [PW-1:0] LAST_PIX  = PW'(LINE_WIDTH - 1);
    localparam logic [CW-1:0] FULL      = CW'(NUM_LB);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT,
        DRAIN
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [CW-1:0] credits;
    logic [PW-1:0] pixCnt;
    logic [11:0]   lineCnt;

    logic        padLine;
    logic        haveSlot;
    logic        emit;
    logic        takeCredit;
    logic        irqLive;
    logic        irqFull;
    logic        giveCredit;
    logic        lineEnd;
    logic [11:0] rowsInc;

    always_comb begin
        padLine    = (PAD_EN != 0) && (lineCnt == 12'd0 || lineCnt == LAST_LINE);
        // mid-line pixels never need a credit; only a line start does
        haveSlot   = (pixCnt != '0) || (credits != '0);
        s_ready    = (state == FEED) && !padLine && haveSlot;
        emit       = (state == FEED) && haveSlot && (padLine || s_valid);
        takeCredit = emit && (pixCnt == '0);
        lineEnd    = emit && (pixCnt == LAST_PIX);
        irqLive    = line_irq && (state != IDLE);
        irqFull    = irqLive && (credits == FULL);
        giveCredit = irqLive && !irqFull;
        rowsInc    = rows_done + 12'(irqLive);
    end

    always_comb begin
        stateNext  = state;
        frame_done = 1'b0;
        lb_clear   = (state == CLEAR);
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) stateNext = CLEAR;
            end
            CLEAR: begin
                stateNext = FEED;
            end
            FEED: begin
                if (lineEnd && lineCnt == LAST_LINE) begin
                    stateNext = DRAIN;
                end else if (pixCnt == '0 && credits == '0) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (giveCredit || credits != '0) stateNext = FEED;
            end
            DRAIN: begin
                if (rowsInc >= ROWS) begin
                    frame_done = 1'b1;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            credits   <= FULL;
            pixCnt    <= '0;
            lineCnt   <= '0;
            rows_done <= '0;
            irq_err   <= 1'b0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
        end else begin
            state     <= stateNext;
            pix_valid <= emit;
            if (emit) pix_data <= padLine ? '0 : s_data;

            if (state == IDLE) begin
                if (start) begin
                    rows_done <= '0;
                    irq_err   <= 1'b0;
                    credits   <= FULL;
                    pixCnt    <= '0;
                    lineCnt   <= '0;
                end else if (line_irq) begin
                    irq_err <= 1'b1;
                end
            end else begin
                credits   <= credits - CW'(takeCredit) + CW'(giveCredit);
                rows_done <= rowsInc;
                if (irqFull) irq_err <= 1'b1;
                if (emit) pixCnt <= lineEnd ? '0 : pixCnt + PW'(1);
                if (lineEnd) lineCnt <= lineCnt + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_line_feed_scheduler.sv
// Directed bench for line_feed_scheduler: 16-pixel lines, 8 source lines,
// padding on; a small line-count model drives line_irq.
module tb_line_feed_scheduler;

    localparam int DW  = 8;
    localparam int LW  = 16;
    localparam int IH  = 8;
    localparam int NLB = 4;
    localparam int PE  = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          frame_done;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          lb_clear;
    logic          line_irq;
    logic [11:0]   rows_done;
    logic          irq_err;

    line_feed_scheduler #(
        .DATA_W(DW),
        .LINE_WIDTH(LW),
        .IMG_HEIGHT(IH),
        .NUM_LB(NLB),
        .PAD_EN(PE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .busy(busy),
        .frame_done(frame_done),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .lb_clear(lb_clear),
        .line_irq(line_irq),
        .rows_done(rows_done),
        .irq_err(irq_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int obsCnt;
    int padCnt;
    int srcSeen;
    int srcAcc;
    int irqs;
    int irqsAtFd;
    int forceAt;
    int srcVal   = 1;
    int mode;
    bit fdSeen;
    bit irqEn;
    bit irqManual;
    bit lastIrq;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic newFrame();
        obsCnt   = 0;
        padCnt   = 0;
        srcSeen  = 0;
        srcAcc   = 0;
        irqs     = 0;
        irqsAtFd = -1;
        forceAt  = -1;
        fdSeen   = 1'b0;
        lastIrq  = 1'b0;
    endtask

    // One clock: drive inputs at the negedge, then check the pixel
    // produced by that edge at the following negedge.
    task automatic cyc();
        bit            acc;
        logic [DW-1:0] accData;
        int            lineIdx;
        s_valid  = (mode == 1) ? 1'b1 :
                   (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        s_data   = srcVal[DW-1:0];
        accData  = s_data;
        line_irq = irqManual;
        if (irqEn && !lastIrq && (obsCnt / LW - 2 - irqs) > 0) line_irq = 1'b1;
        acc = s_valid && s_ready && !reset;
        if (forceAt >= 0 && acc && obsCnt == forceAt) begin
            line_irq = 1'b1;
            forceAt  = -1;
        end
        if (line_irq && !irqManual) irqs++;
        lastIrq = line_irq;
        #1;
        if (frame_done) begin
            fdSeen   = 1'b1;
            irqsAtFd = irqs;
        end
        if (acc) begin
            srcAcc++;
            srcVal++;
        end
        @(negedge clk);
        if (pix_valid) begin
            lineIdx = obsCnt / LW;
            if (PE != 0 && (lineIdx == 0 || lineIdx == IH + 1)) begin
                chk("pad_no_accept", 32'(acc), 32'd0);
                chk("pad_data", 32'(pix_data), 32'd0);
                padCnt++;
            end else begin
                chk("src_latency", 32'(acc), 32'd1);
                chk("src_data", 32'(pix_data), 32'(accData));
                srcSeen++;
            end
            obsCnt++;
        end else if (acc) begin
            chk("src_lost", 32'(pix_valid), 32'd1);
        end
    endtask

    task automatic runUntilFd(input int budget);
        int n;
        n = 0;
        while (!fdSeen && n < budget) begin
            cyc();
            n++;
        end
        chk("frame_done_seen", 32'(fdSeen), 32'd1);
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
        chk({tag, "_lb_clear"}, 32'(lb_clear), 32'd0);
        chk({tag, "_rows_done"}, 32'(rows_done), 32'd0);
        chk({tag, "_irq_err"}, 32'(irq_err), 32'd0);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        start     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        line_irq  = 1'b0;
        mode      = 0;
        irqEn     = 1'b0;
        irqManual = 1'b0;
        newFrame();

        repeat (3) cyc();
        reset = 1'b0;
        chkAllZero("reset");

        newFrame();
        mode  = 1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("clear_high", 32'(lb_clear), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
        cyc();
        chk("clear_one_cycle", 32'(lb_clear), 32'd0);
        chk("busy_hold", 32'(busy), 32'd1);

        repeat (100) cyc();
        chk("stall_pixels", 32'(obsCnt), 32'd64);
        chk("stall_pads", 32'(padCnt), 32'd16);
        chk("stall_accepted", 32'(srcAcc), 32'd48);
        chk("wait_s_ready", 32'(s_ready), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);

        irqEn = 1'b1;
        runUntilFd(400);
        chk("fd_irq_index", 32'(irqsAtFd), 32'd8);
        chk("frame_pixels", 32'(obsCnt), 32'd160);
        chk("frame_pads", 32'(padCnt), 32'd32);
        chk("rows_done_end", 32'(rows_done), 32'd8);
        chk("busy_after_fd", 32'(busy), 32'd0);
        chk("no_irq_err", 32'(irq_err), 32'd0);

        newFrame();
        mode  = 2;
        start = 1'b1;
        cyc();
        start = 1'b0;
        runUntilFd(2000);
        chk("rand_accepted", 32'(srcAcc), 32'd128);
        chk("rand_src_seen", 32'(srcSeen), 32'd128);
        chk("rand_pixels", 32'(obsCnt), 32'd160);
        chk("rand_rows_done", 32'(rows_done), 32'd8);
        chk("rand_busy", 32'(busy), 32'd0);

        newFrame();
        mode    = 1;
        irqEn   = 1'b0;
        forceAt = 48;
        start   = 1'b1;
        cyc();
        start = 1'b0;
        repeat (150) cyc();
        chk("net_zero_pixels", 32'(obsCnt), 32'd80);
        chk("net_zero_irqs", 32'(irqs), 32'd1);
        chk("net_zero_wait", 32'(s_ready), 32'd0);
        irqEn = 1'b1;
        runUntilFd(600);
        chk("net_zero_fd_index", 32'(irqsAtFd), 32'd8);
        chk("net_zero_rows", 32'(rows_done), 32'd8);
        chk("net_zero_err", 32'(irq_err), 32'd0);
        chk("net_zero_total", 32'(obsCnt), 32'd160);

        irqEn = 1'b0;
        mode  = 0;
        reset = 1'b1;
        cyc();
        reset     = 1'b0;
        irqManual = 1'b1;
        cyc();
        irqManual = 1'b0;
        chk("idle_irq_err", 32'(irq_err), 32'd1);
        chk("idle_irq_rows", 32'(rows_done), 32'd0);
        repeat (5) cyc();
        chk("idle_irq_sticky", 32'(irq_err), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        newFrame();
        mode  = 1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_clears_err", 32'(irq_err), 32'd0);
        n = 0;
        while (obsCnt < 56 && n < 200) begin
            cyc();
            n++;
        end
        chk("mid_line3", 32'(obsCnt), 32'd56);
        reset = 1'b1;
        cyc();
        chkAllZero("midreset");
        reset = 1'b0;

        newFrame();
        irqEn = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        runUntilFd(600);
        chk("clean_rows", 32'(rows_done), 32'd8);
        chk("clean_err", 32'(irq_err), 32'd0);
        chk("clean_pixels", 32'(obsCnt), 32'd160);
        chk("clean_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_feed_scheduler.md
Name: line_feed_scheduler

Overview:
- Sequences pixel delivery from an upstream valid/ready pixel source into the 4-line-buffer 3x3 window unit.
- Meters the window unit per line with a credit scheme: one credit per free line buffer, and one credit returned on each line-done interrupt from the window unit.
- Injects optional zero padding lines at the top and bottom of the frame.
- Clears the window unit before each frame and reports frame completion.

Parameters:
- DATA_W, 8, pixel width
- LINE_WIDTH, 512, pixels per line; must match the window unit
- IMG_HEIGHT, 512, source lines per frame, minimum 3
- NUM_LB, 4, line buffers in the window unit, which is the initial credit count
- PAD_EN, 1, 1 = add one zero line before and one after the source lines

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle frame start request; ignored while busy=1
- busy  out  1  high from the cycle after an accepted start until frame_done
- frame_done  out  1  one-cycle pulse when the last output row's line_irq has been received
- s_data  in  DATA_W  source pixel
- s_valid  in  1  source pixel valid
- s_ready  out  1  scheduler accepts s_data this cycle
- pix_data  out  DATA_W  pixel to the window unit (its inData)
- pix_valid  out  1  pixel valid to the window unit (its inDataValid)
- lb_clear  out  1  one-cycle clear to the window unit, ORed with its reset at top level
- line_irq  in  1  one-cycle line-done interrupt from the window unit
- rows_done  out  12  line_irq count in the current frame
- irq_err  out  1  sticky flag; line_irq seen in IDLE or with credits==NUM_LB; cleared by reset or start

Behaviour:
- Derived frame values:
  - L = IMG_HEIGHT + 2*PAD_EN lines written per frame.
  - Expected output rows R = L - 2.
  - Line k is a pad line when PAD_EN=1 and k is 0 or L-1; every other line is a source line.
- Reset values: every output 0. Internally: state=IDLE, credits=NUM_LB, pix_cnt=0, line_cnt=0.
- States:
  - IDLE: start=1 → CLEAR. Also clears rows_done and irq_err and reloads credits=NUM_LB.
  - CLEAR: lb_clear=1 for exactly 1 cycle, then → FEED.
  - FEED, line start (pix_cnt==0):
    - credits==0 → WAIT.
    - Otherwise a pixel may be emitted; the first emitted pixel of a line decrements credits.
  - FEED, pixel emission:
    - Source line: a pixel is emitted when s_valid & s_ready. s_ready = (state==FEED) & (pix_cnt!=0 | credits!=0). s_ready is combinational, with no dependence on s_valid.
    - Pad line: one zero pixel is emitted every cycle (s_ready=0).
  - FEED, counters: each emitted pixel increments pix_cnt. At LINE_WIDTH-1, pix_cnt wraps to 0 and line_cnt increments. After line L-1 completes → DRAIN.
  - WAIT: s_ready=0, no emission. → FEED on the cycle credits becomes nonzero; the first pixel is emitted no earlier than the following cycle.
  - DRAIN: s_ready=0. When rows_done reaches R (counting a line_irq in this same cycle): frame_done=1 for 1 cycle, → IDLE.
- Output timing:
  - pix_data/pix_valid are registered, 1-cycle latency from emission.
  - pix_valid=0 on every cycle without an emission.
  - pix_data holds its last value when pix_valid=0.
- line_irq handling (outside IDLE):
  - rows_done += 1 and credits += 1.
  - If credits is being decremented in the same cycle, the net change is 0 and rows_done still increments.
  - credits saturates at NUM_LB; a line_irq at NUM_LB sets irq_err.
  - In IDLE, line_irq sets irq_err and changes nothing else.
- busy: 1 in CLEAR/FEED/WAIT/DRAIN, 0 in IDLE.
- Reset mid-frame returns all state to reset values on the next edge. The window unit is reset by the same signal. No partial line is resumed.
- Width rules:
  - pix_cnt width is clog2(LINE_WIDTH); line_cnt and rows_done are 12 bits.
  - credits width is clog2(NUM_LB+1).
  - No wrap of line_cnt within a frame.

Test Plan:
1. Reset → all outputs 0. Then start=1 → lb_clear high exactly 1 cycle, and busy=1 from the next cycle.
2. Frame, LINE_WIDTH=16, IMG_HEIGHT=8, PAD_EN=1, s_valid held 1, no irq:
   - Expect 16 zero pixels, then 48 source pixels back-to-back (4 lines total, credits 0).
   - Then s_ready=0 and the state holds in WAIT.
3. Continue test 2 with the bench model issuing line_irq after each row:
   - Expect 10 lines written, the last 16 pixels zero.
   - frame_done after the 8th irq, rows_done=8, busy=0 next cycle.
4. Random s_valid gaps (50%) and a ramp source:
   - pix_valid count equals accepted count.
   - pix_data sequence is the ramp in order with no loss or duplication.
   - 1-cycle latency is checked on every pixel.
5. line_irq in the same cycle as a line's first pixel with credits=1 → credits stays 1. line_irq in IDLE → irq_err=1, rows_done=0, sticky until start.
6. reset asserted mid line 3 → outputs 0 next cycle. A new start then completes a clean frame with rows_done=R=8 and irq_err=0.
